// File: rtl/key_event_pkg.sv
// Shared types and default parameters for the debounced key-event queue.
// The qualifier state names are used by key_event_fifo.
package key_event_pkg;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_QUAL   = 2'd1,
        HELD         = 2'd2,
        RELEASE_QUAL = 2'd3
    } qual_state_e;

    localparam int unsigned DEFAULT_STABLE_CYCLES = 4;
    localparam int unsigned DEFAULT_DEPTH         = 4;

endpackage

// File: rtl/key_fifo.sv
// First-word-fall-through queue of key codes: the head entry is visible on data_o
// whenever the queue is non-empty. A push while full is accepted only alongside a pop.
module key_fifo
    import key_event_pkg::*;
#(
    parameter  int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  key_code_t        data_i,
    output key_code_t        data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    key_code_t        mem_q [DEPTH];
    logic             doPush;
    logic             doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign doPop   = pop_i && !empty_o;
    // When full, the slot being written is the one the pop just released.
    assign doPush  = push_i && (!full_o || doPop);

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    assign data_o  = empty_o ? key_code_t'(4'h0) : mem_q[rdPtr_q];
    assign count_o = count_q;

endmodule

// File: rtl/key_event_fifo.sv
// Debounces keypad presses into one event per physical press and queues the codes
// for a consumer; a sticky flag records any event lost to a full queue.
module key_event_fifo
    import key_event_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int unsigned DEPTH         = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               buttonBus,
    input  logic                     pressed,
    input  logic                     evt_ready,
    output logic                     evt_valid,
    output logic [3:0]               evt_code,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    qual_state_e state_q, state_d;
    logic [7:0]  sampleCnt_q, sampleCnt_d;
    key_code_t   cand_q, cand_d;
    logic        overflow_q, overflow_d;
    logic        keyDown;
    logic        lastSample;
    logic        pushEvt;
    logic        popEvt;
    logic        fifoFull;
    logic        fifoEmpty;
    key_code_t   headCode;

    // The scanner drives pressed low while a key is held.
    assign keyDown    = !pressed;
    assign lastSample = (sampleCnt_q + 8'd1) == 8'(STABLE_CYCLES);

    always_comb begin
        state_d     = state_q;
        sampleCnt_d = sampleCnt_q;
        cand_d      = cand_q;
        pushEvt     = 1'b0;
        case (state_q)
            IDLE: begin
                if (keyDown) begin
                    state_d     = PRESS_QUAL;
                    cand_d      = buttonBus;
                    sampleCnt_d = 8'd1;
                end
            end
            PRESS_QUAL: begin
                if (!keyDown) begin
                    state_d = IDLE;
                end else if (buttonBus != cand_q) begin
                    cand_d      = buttonBus;
                    sampleCnt_d = 8'd1;
                end else begin
                    sampleCnt_d = sampleCnt_q + 8'd1;
                    if (lastSample) begin
                        pushEvt = 1'b1;
                        state_d = HELD;
                    end
                end
            end
            HELD: begin
                if (!keyDown) begin
                    state_d     = RELEASE_QUAL;
                    sampleCnt_d = 8'd1;
                end
            end
            RELEASE_QUAL: begin
                if (keyDown) begin
                    state_d = HELD;
                end else begin
                    sampleCnt_d = sampleCnt_q + 8'd1;
                    if (lastSample) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign popEvt = evt_valid && evt_ready;

    // A drop sets the flag even if a clear arrives in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (pushEvt && fifoFull && !popEvt) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sampleCnt_q <= 8'd0;
            cand_q      <= 4'h0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sampleCnt_q <= sampleCnt_d;
            cand_q      <= cand_d;
            overflow_q  <= overflow_d;
        end
    end

    key_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pushEvt),
        .pop_i   (popEvt),
        .data_i  (cand_q),
        .data_o  (headCode),
        .count_o (fifo_count),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign evt_valid = !fifoEmpty;
    assign evt_code  = headCode;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_fifo.sv
// Directed test of key_event_fifo with default parameters (4 stable samples, 4 entries).
// Inputs change 1 time unit after a rising edge and outputs are checked there too.
module tb_key_event_fifo;

    logic       clk;
    logic       rst;
    logic [3:0] buttonBus;
    logic       pressed;
    logic       evt_ready;
    logic       evt_valid;
    logic [3:0] evt_code;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       clr_overflow;

    int nAsserts = 0;
    int nFail    = 0;

    key_event_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .buttonBus    (buttonBus),
        .pressed      (pressed),
        .evt_ready    (evt_ready),
        .evt_valid    (evt_valid),
        .evt_code     (evt_code),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic p, input logic [3:0] code, input logic rdy,
                                 input logic clr, input int cycles);
        pressed      = p;
        buttonBus    = code;
        evt_ready    = rdy;
        clr_overflow = clr;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic expValid, input logic [3:0] expCode,
                               input int expCount, input logic expOvf);
        nAsserts++;
        assert (evt_valid === expValid) else begin
            nFail++;
            $error("[TB] FAIL %s.valid observed=%0b expected=%0b", tag, evt_valid, expValid);
        end
        nAsserts++;
        assert (evt_code === expCode) else begin
            nFail++;
            $error("[TB] FAIL %s.code observed=%0h expected=%0h", tag, evt_code, expCode);
        end
        nAsserts++;
        assert (fifo_count === 3'(expCount)) else begin
            nFail++;
            $error("[TB] FAIL %s.count observed=%0d expected=%0d", tag, fifo_count, expCount);
        end
        nAsserts++;
        assert (overflow === expOvf) else begin
            nFail++;
            $error("[TB] FAIL %s.overflow observed=%0b expected=%0b", tag, overflow, expOvf);
        end
    endtask

    // Four stable key-down samples qualify; five key-up samples fully release.
    task automatic pressKey(input logic [3:0] code);
        applyStimulus(1'b0, code, 1'b0, 1'b0, 4);
        applyStimulus(1'b1, code, 1'b0, 1'b0, 5);
    endtask

    task automatic popOne();
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b0, 1);
        evt_ready = 1'b0;
    endtask

    initial begin
        logic [3:0] fullCodes [4];
        logic [3:0] swapCodes [4];
        fullCodes = '{4'h1, 4'h2, 4'h3, 4'h4};
        swapCodes = '{4'hB, 4'hC, 4'hD, 4'hE};

        rst = 1'b1;
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 2);
        checkOutput("reset", 1'b0, 4'h0, 0, 1'b0);
        rst = 1'b0;

        applyStimulus(1'b1, 4'h0, 1'b1, 1'b0, 2);
        checkOutput("readyWhileEmpty", 1'b0, 4'h0, 0, 1'b0);

        // Single press of code 5: event visible right after the fourth sample.
        applyStimulus(1'b0, 4'h5, 1'b0, 1'b0, 3);
        checkOutput("press5.notYet", 1'b0, 4'h0, 0, 1'b0);
        applyStimulus(1'b0, 4'h5, 1'b0, 1'b0, 1);
        checkOutput("press5.event", 1'b1, 4'h5, 1, 1'b0);
        applyStimulus(1'b1, 4'h5, 1'b0, 1'b0, 6);
        checkOutput("press5.released", 1'b1, 4'h5, 1, 1'b0);
        popOne();
        checkOutput("press5.popped", 1'b0, 4'h0, 0, 1'b0);

        // Candidate code changes restart qualification; long hold with code change adds nothing.
        applyStimulus(1'b0, 4'h3, 1'b0, 1'b0, 2);
        applyStimulus(1'b0, 4'h7, 1'b0, 1'b0, 3);
        checkOutput("code37.notYet", 1'b0, 4'h0, 0, 1'b0);
        applyStimulus(1'b0, 4'h7, 1'b0, 1'b0, 1);
        checkOutput("code37.event", 1'b1, 4'h7, 1, 1'b0);
        applyStimulus(1'b0, 4'h7, 1'b0, 1'b0, 20);
        applyStimulus(1'b0, 4'h9, 1'b0, 1'b0, 20);
        checkOutput("code37.held", 1'b1, 4'h7, 1, 1'b0);
        applyStimulus(1'b1, 4'h7, 1'b0, 1'b0, 5);
        popOne();
        checkOutput("code37.popped", 1'b0, 4'h0, 0, 1'b0);

        // Three samples then key-up is one short of qualifying.
        applyStimulus(1'b0, 4'h6, 1'b0, 1'b0, 3);
        applyStimulus(1'b1, 4'h6, 1'b0, 1'b0, 2);
        checkOutput("shortPress", 1'b0, 4'h0, 0, 1'b0);

        // Release bounce must not create a second event.
        applyStimulus(1'b0, 4'h2, 1'b0, 1'b0, 4);
        applyStimulus(1'b1, 4'h2, 1'b0, 1'b0, 2);
        applyStimulus(1'b0, 4'h2, 1'b0, 1'b0, 3);
        applyStimulus(1'b1, 4'h2, 1'b0, 1'b0, 6);
        checkOutput("bounce", 1'b1, 4'h2, 1, 1'b0);
        popOne();
        checkOutput("bounce.popped", 1'b0, 4'h0, 0, 1'b0);

        // Fill, overflow with a coincident clear (set wins), then drain in order.
        for (int i = 0; i < 4; i++) pressKey(fullCodes[i]);
        checkOutput("fill.full", 1'b1, 4'h1, 4, 1'b0);
        applyStimulus(1'b0, 4'h5, 1'b0, 1'b0, 3);
        applyStimulus(1'b0, 4'h5, 1'b0, 1'b1, 1);
        checkOutput("fill.overflow", 1'b1, 4'h1, 4, 1'b1);
        applyStimulus(1'b1, 4'h5, 1'b0, 1'b0, 5);
        for (int i = 0; i < 4; i++) begin
            checkOutput("fill.drain", 1'b1, fullCodes[i], 4 - i, 1'b1);
            popOne();
        end
        checkOutput("fill.empty", 1'b0, 4'h0, 0, 1'b1);
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b1, 1);
        checkOutput("fill.cleared", 1'b0, 4'h0, 0, 1'b0);

        // Push coinciding with a pop while full: head leaves, new code joins the tail.
        pressKey(4'hA);
        for (int i = 0; i < 3; i++) pressKey(swapCodes[i]);
        checkOutput("swap.full", 1'b1, 4'hA, 4, 1'b0);
        applyStimulus(1'b0, 4'hE, 1'b0, 1'b0, 3);
        applyStimulus(1'b0, 4'hE, 1'b1, 1'b0, 1);
        checkOutput("swap.pushPop", 1'b1, 4'hB, 4, 1'b0);
        applyStimulus(1'b1, 4'hE, 1'b0, 1'b0, 5);
        for (int i = 0; i < 4; i++) begin
            checkOutput("swap.drain", 1'b1, swapCodes[i], 4 - i, 1'b0);
            popOne();
        end
        checkOutput("swap.empty", 1'b0, 4'h0, 0, 1'b0);

        // Reset mid-qualification with events queued; the held key requalifies afterwards.
        pressKey(4'h8);
        pressKey(4'h9);
        applyStimulus(1'b0, 4'hA, 1'b0, 1'b0, 2);
        checkOutput("rst.before", 1'b1, 4'h8, 2, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 4'hA, 1'b0, 1'b0, 1);
        checkOutput("rst.cleared", 1'b0, 4'h0, 0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 4'hA, 1'b0, 1'b0, 3);
        checkOutput("rst.requal", 1'b0, 4'h0, 0, 1'b0);
        applyStimulus(1'b0, 4'hA, 1'b0, 1'b0, 1);
        checkOutput("rst.event", 1'b1, 4'hA, 1, 1'b0);
        applyStimulus(1'b0, 4'hA, 1'b0, 1'b0, 10);
        checkOutput("rst.held", 1'b1, 4'hA, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule

// File: doc/key_event_fifo.md
KEY_EVENT_FIFO -- requirements
Module: key_event_fifo

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive identical samples needed to qualify a press or release; legal range 2..255.
REQ-002 Parameter DEPTH, default 4, is the FIFO entry count; it SHALL be a power of two, 2..16.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 buttonBus  input  4  key code from the keypad scanner, valid when key-down.
REQ-006 pressed  input  1  upstream encoding: high = no key active, low = key-down.
REQ-007 evt_ready  input  1  consumer accepts the head event.
REQ-008 evt_valid  output  1  FIFO non-empty; a head event is presented.
REQ-009 evt_code  output  4  head event key code; 4'h0 when empty.
REQ-010 fifo_count  output  $clog2(DEPTH)+1  number of stored events.
REQ-011 overflow  output  1  sticky flag: an event was dropped.
REQ-012 clr_overflow  input  1  clears overflow.

Function
REQ-013 Key-down SHALL be defined as pressed==0; inputs are sampled directly each cycle, with no synchroniser.
REQ-014 The qualifier FSM SHALL have the states IDLE, PRESS_QUAL, HELD and RELEASE_QUAL, plus an 8-bit sample counter and a 4-bit candidate register.
REQ-015 IDLE with key-down: go to PRESS_QUAL, candidate<=buttonBus, counter<=1; otherwise remain in IDLE.
REQ-016 PRESS_QUAL with key-up: go to IDLE with no event.
REQ-017 PRESS_QUAL with key-down and buttonBus!=candidate: candidate<=buttonBus, counter<=1, remain in PRESS_QUAL.
REQ-018 PRESS_QUAL with key-down and buttonBus==candidate: counter increments; the sample bringing it to STABLE_CYCLES SHALL push candidate into the FIFO and go to HELD.
REQ-019 HELD SHALL ignore code changes and emit no further events; key-up goes to RELEASE_QUAL with counter<=1.
REQ-020 RELEASE_QUAL with key-down: return to HELD.
REQ-021 RELEASE_QUAL with key-up: counter increments; reaching STABLE_CYCLES goes to IDLE.
REQ-022 Each physical press SHALL produce exactly one event.
REQ-023 Push-to-output latency SHALL be 1 cycle: evt_valid and evt_code appear on the cycle after the qualifying sample when the FIFO was empty.
REQ-024 The FIFO SHALL be first-word-fall-through; a pop occurs on any cycle with evt_valid && evt_ready.
REQ-025 evt_ready while empty SHALL have no effect.
REQ-026 Push and pop in the same cycle SHALL both take effect, including when full; count is unchanged and overflow is not set.
REQ-027 Push when full without a pop SHALL drop the event, leave the FIFO unchanged and set overflow.
REQ-028 overflow SHALL stay set until clr_overflow; if a set and a clear occur in the same cycle, the set wins.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH; fifo_count ranges 0..DEPTH.

Reset
REQ-030 On rst the block SHALL enter IDLE and clear counter, candidate, pointers, fifo_count and overflow; evt_valid=0 and evt_code=4'h0.
REQ-031 Reset SHALL take priority over all other inputs.
REQ-032 A key held through deassertion of rst SHALL be requalified from IDLE and produce one event.

Structure
REQ-033 Package key_event_pkg SHALL hold typedef key_code_t (logic [3:0]), the FSM state enum and the default parameter constants.
REQ-034 Sub-module key_fifo SHALL implement the parameterised FWFT FIFO, exposing push, pop, data, count and full/empty.
REQ-035 The qualifier FSM SHALL be in key_event_fifo.

Verification
REQ-036 Defaults; pressed=0, buttonBus=4'h5 for 4 cycles, then pressed=1 -> exactly one push; evt_valid=1 with evt_code=4'h5 on cycle 5, fifo_count=1.
REQ-037 pressed=0 with codes 3,3,7,7,7,7 -> single event 4'h7; held for 40 further cycles -> no additional event.
REQ-038 Bounce: key-down 4 cycles (code 2), key-up 2 cycles, key-down 3 cycles, then release -> one event only.
REQ-039 evt_ready=0; five distinct qualified presses (1,2,3,4,5) -> FIFO holds 1..4, fifo_count=4, overflow=1; draining yields 1,2,3,4 in order.
REQ-040 FIFO full; a qualifying push coincides with evt_ready=1 -> head popped, new code at tail, fifo_count stays 4, overflow remains 0.
REQ-041 rst asserted mid-PRESS_QUAL with 2 events queued -> evt_valid=0 and fifo_count=0 next cycle; key held after rst -> one new event after STABLE_CYCLES samples.
